riscv32ima_prefetch: RTL

Parametrised instruction prefetch unit for the riscv32ima core, between the instruction memory port and decode. It fetches DATA_WIDTH-bit lines, splits each line into 32-bit instruction words, and buffers them in a FIFO_DEPTH-entry queue. Decode consumes one instruction per valid/ready handshake. A redirect from writeback flushes the queue and any in-flight line, then restarts fetch at the new PC, including mid-line targets.

---
 rtl/riscv32ima_prefetch.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/riscv32ima_prefetch.sv
// Instruction prefetch unit: fetches memory lines, splits them into 32-bit
// words and queues {address, word} pairs for decode. A writeback redirect
// flushes the queue and any in-flight line and restarts at the new PC.
module riscv32ima_prefetch #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 64,
  parameter int unsigned           FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h1000_0000
) (
  input  logic                  clk,
  input  logic                  nrst,
  output logic                  fetch_valid,
  input  logic                  fetch_ready,
  output logic [ADDR_WIDTH-1:0] fetch_address,
  output logic [31:0]           fetch_data,
  input  logic                  wback_pc_wen,
  input  logic [ADDR_WIDTH-1:0] wback_pc,
  output logic                  i_ncs,
  output logic                  i_nwe,
  output logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] i_wmask,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  i_stall
);

  localparam int unsigned W          = DATA_WIDTH / 32;
  localparam int unsigned LINE_BYTES = DATA_WIDTH / 8;
  localparam int unsigned WB         = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned PW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW         = $clog2(FIFO_DEPTH + 1);
  // count + two reserved lines never exceeds 3*FIFO_DEPTH, so two extra bits suffice
  localparam int unsigned SW         = CW + 2;

  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(LINE_BYTES - 1);
  localparam logic [SW-1:0]         W_EXT     = SW'(W);
  localparam logic [SW-1:0]         D_EXT     = SW'(FIFO_DEPTH);

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic                  inflight_q, inflight_d;
  logic                  drop_q, drop_d;
  logic [WB-1:0]         off_q, off_d;
  logic [ADDR_WIDTH-1:0] line_q, line_d;
  logic [PW-1:0]         head_q, head_d;
  logic [CW-1:0]         count_q, count_d;

  logic [ADDR_WIDTH-1:0] addr_q [FIFO_DEPTH];
  logic [31:0]           data_q [FIFO_DEPTH];

  logic                  issue, accept, ret, push, pop;
  logic [SW-1:0]         need, npush;
  logic [WB-1:0]         off_new;
  logic [W-1:0]          wr_en;
  logic [PW-1:0]         wr_idx [W];
  logic                  unused_pc_bits;

  // The low two redirect bits are defined as don't-care.
  assign unused_pc_bits = ^wback_pc[1:0];

  // Reserve a full line for an outstanding request so its data always fits.
  assign need    = SW'(count_q) + (inflight_q ? W_EXT : '0) + W_EXT;
  assign issue   = nrst & ~wback_pc_wen & (need <= D_EXT);
  assign i_ncs   = ~issue;
  assign i_nwe   = 1'b1;
  assign i_wdata = '0;
  assign i_wmask = '0;
  assign i_addr  = fetch_pc_q & ~LINE_MASK;

  assign accept  = issue & ~i_stall;
  assign ret     = inflight_q & ~i_stall;
  assign push    = ret & ~drop_q & ~wback_pc_wen;
  assign pop     = fetch_valid & fetch_ready;
  assign off_new = WB'((fetch_pc_q & LINE_MASK) >> 2);
  assign npush   = push ? (W_EXT - SW'(off_q)) : '0;

  assign fetch_valid   = (count_q != '0);
  assign fetch_address = addr_q[head_q];
  assign fetch_data    = data_q[head_q];

  // Next-state for PC, in-flight tracking and queue occupancy.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    off_d      = off_q;
    line_d     = line_q;
    inflight_d = accept | (inflight_q & i_stall);
    head_d     = head_q + PW'(pop);
    count_d    = CW'(SW'(count_q) + npush - SW'(pop));
    drop_d     = ret ? 1'b0 : drop_q;
    if (accept) begin
      off_d      = off_new;
      line_d     = i_addr;
      fetch_pc_d = i_addr + ADDR_WIDTH'(LINE_BYTES);
    end
    if (wback_pc_wen) begin
      fetch_pc_d = {wback_pc[ADDR_WIDTH-1:2], 2'b00};
      count_d    = '0;
      // a line still stalled in flight belongs to the old stream
      drop_d     = inflight_q & i_stall;
    end
  end

  // Per-word write enables and queue slots for the returning line.
  always_comb begin
    for (int k = 0; k < W; k++) begin
      wr_en[k]  = push && (k >= int'(off_q));
      wr_idx[k] = head_q + count_q[PW-1:0] + PW'(k) - PW'(off_q);
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
      off_q      <= '0;
      line_q     <= '0;
      head_q     <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      off_q      <= off_d;
      line_q     <= line_d;
      head_q     <= head_d;
      count_q    <= count_d;
    end
  end

  // Queue storage; cleared on reset so the head outputs start at zero.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      for (int k = 0; k < W; k++) begin
        if (wr_en[k]) begin
          addr_q[wr_idx[k]] <= line_q + ADDR_WIDTH'(4 * k);
          data_q[wr_idx[k]] <= i_rdata[32*k +: 32];
        end
      end
    end
  end

endmodule
